seg_serial_display: RTL
=======================

# seg_serial_display

Parametrised serial seven-segment driver for the board's shift-register display chain. It generalises the fixed 8-digit display driver to any digit count and any shift-clock rate. It adds a start/busy/done handshake and per-digit blanking, point and flash control. It sits between the CPU-side display port registers and the board pins, and converts one latched frame into a single serial shift burst followed by a latch pulse.

## Interface
- DIGITS, 8: number of seven-segment digits in the chain (1..16).
- CLK_DIV, 2: seg_clk half-period in clk cycles (≥1).
- ACTIVE_LOW, 1: 1 = a lit segment is shifted as 0; 0 = lit is 1.
- clk  in  1  system clock; every register is clocked on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- text  in  1  1 = hex mode (nibbles decoded); 0 = graphic mode (raw bytes).
- flash  in  1  flash phase; 1 blanks the digits whose les bit is set.
- data  in  8*DIGITS  hex mode uses [4*DIGITS-1:0], one nibble per digit; graphic mode uses one byte per digit, {dp,g,f,e,d,c,b,a}.
- point  in  DIGITS  decimal point per digit (hex mode only).
- les  in  DIGITS  flash enable per digit.
- seg_clk  out  1  shift clock; idles low.
- seg_sout  out  1  serial data; stable around each seg_clk rising edge.
- seg_pen  out  1  display latch/enable; low while shifting.
- seg_clrn  out  1  active-low chain clear.
- busy  out  1  a frame is in progress.
- done  out  1  one-cycle pulse when a frame completes.

## Operation
- Reset values: seg_clk=0, seg_sout=0, seg_pen=0, seg_clrn=0, busy=0, done=0, state=IDLE.
- seg_clrn goes to 1 on the first clk edge after rst deasserts and stays 1.
- FSM states: IDLE, LOAD, SHIFT, LATCH.
- IDLE: when start=1, go to LOAD. start is ignored in every other state.
- LOAD: capture text, flash, data, point and les. Encode every digit into a byte and load the 8*DIGITS-bit shift register. Set busy=1 and seg_pen=0.
- Hex encoding: the standard 0–F table, active-high gfedcba (0→3F, 8→7F, F→71). dp is set to point[i]. Invert the whole byte if ACTIVE_LOW=1.
- Graphic encoding: the raw byte is passed through unchanged. point is ignored.
- Blanking: if flash=1 and les[i]=1, digit i becomes "all unlit" (FF when ACTIVE_LOW=1, 00 otherwise). Blanking applies in both modes.
- SHIFT order: digit DIGITS-1 first, each byte MSB (dp) first, 8*DIGITS bits in total.
- Per bit: seg_sout is updated while seg_clk=0, seg_clk stays low for CLK_DIV cycles, then high for CLK_DIV cycles.
- After the last high phase, seg_clk returns low and the FSM enters LATCH.
- LATCH (1 cycle): seg_pen=1, done=1, busy=0, then IDLE. seg_pen stays 1 until the next LOAD.
- An input change during a frame has no effect on that frame.

## Timing
- start high in cycle 0 → LOAD in cycle 1 → SHIFT from cycle 2.
- done is asserted in cycle 2+16*DIGITS*CLK_DIV (258 for the defaults).
- start held high continuously: back-to-back frames, with one IDLE cycle between done and the next LOAD.
- Reset mid-frame: all outputs return immediately to their reset values. The frame is aborted with no done pulse, and seg_pen stays 0 until the next completed frame.
- Bit counter: $clog2(8*DIGITS) bits. Divider counter: $clog2(CLK_DIV)+1 bits. Neither wraps; each is reloaded at the start of every bit or phase.

## Structure
- Package seg_disp_pkg:
  - FSM state enum.
  - 16-entry hex-to-segment constant table.
  - Blank-byte constants for both polarities.
- Sub-module seg_hex_encoder (combinational, one instance per digit):
  - inputs: nibble, raw byte, text, point, blank, ACTIVE_LOW;
  - output: the encoded byte.
- The top level holds the FSM, clock divider, bit counter and shift register.

## Test plan
- Defaults, text=1, data[31:0]=0x00000000, point=0, les=0, start pulse:
  - 64 bits shifted, each byte C0;
  - done in cycle 258;
  - seg_pen rises in the same cycle.
- text=1, data[31:0]=0x80000000, point=8'h80:
  - the first byte shifted is 00 (8 with dp, active-low);
  - the remaining bytes are C0.
- text=0, data=64'h0123456789ABCDEF, flash=1, les=8'h01:
  - shifted stream is 01 23 45 67 89 AB CD FF;
  - the last digit is blanked.
- DIGITS=4, CLK_DIV=1: 32 bits shifted and done in cycle 66. Check the seg_clk period is 2 cycles and seg_sout is stable at every rising edge.
- rst asserted at cycle 100 of a frame:
  - outputs go to reset values the same cycle;
  - no done pulse;
  - a new start after reset completes a full frame normally.
- start pulsed again while busy=1: ignored, and exactly one done pulse is seen.

Source files
------------

// File: rtl/seg_serial_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_disp_pkg
//  Description : Shared types and constants for the serial seven-segment
//                display driver (FSM states, hex glyph table, blank bytes).
//  Revision    : 1.0  initial release
// ============================================================================
package seg_disp_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } seg_state_e;

    // Active-high gfedcba glyphs for 0..F; element 0 is the rightmost entry
    localparam logic [15:0][6:0] c_HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // "All segments unlit" for each output polarity
    localparam logic [7:0] c_BLANK_AL = 8'hFF;
    localparam logic [7:0] c_BLANK_AH = 8'h00;

endpackage
`default_nettype wire

// File: rtl/seg_serial_display_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg_serial_display_if
//  Description : Frame request/status port and board pins of the serial
//                seven-segment driver, grouped for a single module port.
//  Revision    : 1.0  initial release
// ============================================================================
interface seg_serial_display_if #(
    parameter int DIGITS = 8
);
    logic                  start;
    logic                  text;
    logic                  flash;
    logic [8*DIGITS-1:0]   data;
    logic [DIGITS-1:0]     point;
    logic [DIGITS-1:0]     les;
    logic                  seg_clk;
    logic                  seg_sout;
    logic                  seg_pen;
    logic                  seg_clrn;
    logic                  busy;
    logic                  done;

    // Requester side: drives frame contents, observes status and pins
    modport master (
        output start, text, flash, data, point, les,
        input  seg_clk, seg_sout, seg_pen, seg_clrn, busy, done
    );

    // Driver side
    modport slave (
        input  start, text, flash, data, point, les,
        output seg_clk, seg_sout, seg_pen, seg_clrn, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/seg_serial_display_hex_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg_hex_encoder
//  Description : Encodes one digit into its shifted byte {dp,g,f,e,d,c,b,a}:
//                hex glyph lookup or raw passthrough, with blanking.
//  Revision    : 1.0  initial release
// ============================================================================
module seg_hex_encoder
    import seg_disp_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  wire logic [3:0] i_nibble,
    input  wire logic [7:0] i_raw,
    input  wire logic       i_text,
    input  wire logic       i_point,
    input  wire logic       i_blank,
    output logic [7:0]      o_seg
);

    logic [7:0] w_hex;

    // Select glyph, raw byte or blank; only the hex glyph follows polarity,
    // raw graphic bytes are sent exactly as supplied
    always_comb begin
        w_hex = {i_point, c_HEX_SEG[i_nibble]};
        if (ACTIVE_LOW) begin
            w_hex = ~w_hex;
        end
        o_seg = i_text ? w_hex : i_raw;
        if (i_blank) begin
            o_seg = ACTIVE_LOW ? c_BLANK_AL : c_BLANK_AH;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_serial_display.sv
`default_nettype none
// ============================================================================
//  Module      : seg_serial_display
//  Description : Converts one latched display frame into a serial shift burst
//                on seg_clk/seg_sout followed by a seg_pen latch pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module seg_serial_display
    import seg_disp_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int CLK_DIV    = 2,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    seg_serial_display_if.slave   bus
);

    localparam int NBITS = 8 * DIGITS;
    localparam int BIT_W = $clog2(NBITS);
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam logic [BIT_W-1:0] c_BIT_LAST = BIT_W'(NBITS - 1);
    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [NBITS-1:0] w_frame;

    seg_state_e       r_state_q,   w_state_d;
    logic [NBITS-1:0] r_shreg_q,   w_shreg_d;
    logic [BIT_W-1:0] r_bit_q,     w_bit_d;
    logic [DIV_W-1:0] r_div_q,     w_div_d;
    logic             r_seg_clk_q, w_seg_clk_d;
    logic             r_sout_q,    w_sout_d;
    logic             r_pen_q,     w_pen_d;
    logic             r_clrn_q,    w_clrn_d;
    logic             r_busy_q,    w_busy_d;
    logic             r_done_q,    w_done_d;

    // One encoder per digit; digit i occupies frame byte i
    for (genvar i = 0; i < DIGITS; i++) begin : g_enc
        seg_hex_encoder #(
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_enc (
            .i_nibble (bus.data[4*i +: 4]),
            .i_raw    (bus.data[8*i +: 8]),
            .i_text   (bus.text),
            .i_point  (bus.point[i]),
            .i_blank  (bus.flash & bus.les[i]),
            .o_seg    (w_frame[8*i +: 8])
        );
    end

    // Next-state logic: frame sequencing, seg_clk divider and bit shifting
    always_comb begin
        w_state_d   = r_state_q;
        w_shreg_d   = r_shreg_q;
        w_bit_d     = r_bit_q;
        w_div_d     = r_div_q;
        w_seg_clk_d = r_seg_clk_q;
        w_sout_d    = r_sout_q;
        w_pen_d     = r_pen_q;
        w_clrn_d    = 1'b1;
        w_busy_d    = r_busy_q;
        w_done_d    = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_d = ST_LOAD;
                    w_busy_d  = 1'b1;
                    w_pen_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                // The shift register is the frame snapshot, so later input
                // changes cannot disturb this frame
                w_shreg_d   = w_frame;
                w_sout_d    = w_frame[NBITS-1];
                w_seg_clk_d = 1'b0;
                w_div_d     = c_DIV_LAST;
                w_bit_d     = c_BIT_LAST;
                w_state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (r_div_q != '0) begin
                    w_div_d = r_div_q - DIV_W'(1);
                end else begin
                    w_div_d = c_DIV_LAST;
                    if (!r_seg_clk_q) begin
                        w_seg_clk_d = 1'b1;
                    end else begin
                        // Falling seg_clk edge: present the next bit here so
                        // it is settled a full low phase before the rise
                        w_seg_clk_d = 1'b0;
                        if (r_bit_q == '0) begin
                            w_state_d = ST_LATCH;
                            w_pen_d   = 1'b1;
                            w_done_d  = 1'b1;
                            w_busy_d  = 1'b0;
                        end else begin
                            w_bit_d   = r_bit_q - BIT_W'(1);
                            w_shreg_d = {r_shreg_q[NBITS-2:0], 1'b0};
                            w_sout_d  = r_shreg_q[NBITS-2];
                        end
                    end
                end
            end
            ST_LATCH: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset forces pins to their safe values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q   <= ST_IDLE;
            r_shreg_q   <= '0;
            r_bit_q     <= '0;
            r_div_q     <= '0;
            r_seg_clk_q <= 1'b0;
            r_sout_q    <= 1'b0;
            r_pen_q     <= 1'b0;
            r_clrn_q    <= 1'b0;
            r_busy_q    <= 1'b0;
            r_done_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_shreg_q   <= w_shreg_d;
            r_bit_q     <= w_bit_d;
            r_div_q     <= w_div_d;
            r_seg_clk_q <= w_seg_clk_d;
            r_sout_q    <= w_sout_d;
            r_pen_q     <= w_pen_d;
            r_clrn_q    <= w_clrn_d;
            r_busy_q    <= w_busy_d;
            r_done_q    <= w_done_d;
        end
    end

    assign bus.seg_clk  = r_seg_clk_q;
    assign bus.seg_sout = r_sout_q;
    assign bus.seg_pen  = r_pen_q;
    assign bus.seg_clrn = r_clrn_q;
    assign bus.busy     = r_busy_q;
    assign bus.done     = r_done_q;

endmodule
`default_nettype wire
